zap_tlb_lookup_ctrl: RTL
========================

Name: zap_tlb_lookup_ctrl

Overview:
Sequences a single-port-pair tag RAM with single-cycle invalidate (1-cycle read latency, per-entry valid bit) as a direct-mapped TLB. Accepts one translation request at a time, reads and compares the tag, and issues a page-walk request on a miss. Writes the walk result back into the RAM and serialises TLB-invalidate commands against lookups. Sits between the core's MMU request port and the tag RAM instance.

Parameters:
DEPTH, 32, number of TLB entries (power of 2, >=2); IDX_W = clog2(DEPTH)
VA_W, 20, virtual page number width; TAG_W = VA_W - IDX_W
DATA_W, 24, translation payload width; RAM entry width = TAG_W + DATA_W, {tag, data}

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_req_valid  in  1  lookup request
i_req_vpn  in  VA_W  virtual page number; index = vpn[IDX_W-1:0], tag = vpn[VA_W-1:IDX_W]
o_req_ready  out  1  request accepted when valid&ready
o_rsp_valid  out  1  response valid, held until i_rsp_ready
i_rsp_ready  in  1  response consumed
o_rsp_hit  out  1  1 = TLB hit, 0 = filled from walk
o_rsp_fault  out  1  walk reported fault
o_rsp_data  out  DATA_W  translation payload
o_walk_req  out  1  page-walk request, level, held until i_walk_done
o_walk_vpn  out  VA_W  VPN to walk
i_walk_done  in  1  walk complete, 1-cycle pulse
i_walk_fault  in  1  qualifies i_walk_done
i_walk_data  in  DATA_W  walk result, valid with i_walk_done
i_inv_req  in  1  invalidate-all pulse
o_inv_ack  out  1  1-cycle pulse when RAM invalidate issued
o_ram_ren, o_ram_raddr  out  1, IDX_W  RAM read port
o_ram_wen, o_ram_waddr, o_ram_wdata  out  1, IDX_W, TAG_W+DATA_W  RAM write port
o_ram_inv  out  1  RAM clear-all
i_ram_rdata, i_ram_rdav  in  TAG_W+DATA_W, 1  RAM read data/valid, 1 cycle after ren
o_hit_cnt, o_miss_cnt  out  16, 16  saturating perf counters

Behaviour:
- Reset: state IDLE; all outputs 0 (o_req_ready 0 during reset cycle, 1 in first IDLE cycle); inv_pending, discard, counters, captured VPN cleared. Reset mid-walk drops o_walk_req immediately; no RAM write.
- inv_pending set by i_inv_req in any state; cleared when serviced.
- IDLE: if inv_pending: o_ram_inv=1, o_inv_ack=1, o_req_ready=0 this cycle, clear inv_pending. Else o_req_ready=1; on accept capture vpn, o_ram_ren=1, o_ram_raddr=i_req_vpn index (combinational) -> CMP.
- i_inv_req arriving in the same IDLE cycle as i_req_valid: the request is accepted; the invalidate is serviced on the next IDLE cycle.
- CMP: hit = i_ram_rdav && rdata tag == captured tag. Hit: register rsp {hit=1, fault=0, data=rdata payload}, hit_cnt++ -> RESP. Miss: miss_cnt++ -> WALK.
- WALK: o_walk_req=1, o_walk_vpn=captured vpn. On i_walk_done: fault -> rsp {hit=0, fault=1, data=0} -> RESP, no write; else latch i_walk_data -> FILL.
- FILL (1 cycle): o_ram_wen=1, waddr=index, wdata={tag, walk data}, unless discard=1 (write suppressed); -> RESP with {hit=0, fault=0, data=walk data}.
- discard set when i_inv_req arrives while in CMP, WALK or FILL; cleared on entering IDLE. The pending invalidate still executes in the next IDLE cycle.
- RESP: o_rsp_valid=1 with stable fields until i_rsp_ready; -> IDLE on handshake.
- Latency from accept: hit rsp_valid at +2 cycles; miss fill rsp_valid 2 cycles after i_walk_done.
- One outstanding request; no RAM read/write address hazard.
- Counters saturate at 16'hFFFF; cleared only by reset.

Test Plan:
- Reset, then vpn=0x00005 with empty RAM -> miss, o_walk_req with vpn 0x00005; walk_done data 0xABCDEF -> RAM write idx 5, rsp hit=0 data 0xABCDEF; miss_cnt=1.
- Repeat vpn 0x00005 -> rsp_valid 2 cycles after accept, hit=1, data 0xABCDEF, no walk; hit_cnt=1.
- vpn 0x00025 (same idx 5, tag differs) -> miss and walk; fill overwrites idx 5; then 0x00005 misses.
- i_inv_req during WALK -> FILL write suppressed, response still returned; next IDLE cycle o_ram_inv=1 and o_inv_ack=1; following lookup misses.
- Walk fault -> rsp fault=1 hit=0 data 0, no RAM write; i_rsp_ready held low 5 cycles -> response fields stable; reset mid-WALK -> o_walk_req=0 next cycle, counters 0.
- Force 65536 hits -> o_hit_cnt stays at 0xFFFF.

Source files
------------

// File: rtl/zap_tlb_lookup_ctrl.sv
// zap_tlb_lookup_ctrl
// Direct-mapped TLB lookup sequencer in front of a tag RAM that has a
// 1-cycle read latency, a per-entry valid bit and a single-cycle clear-all.
// One translation is in flight at a time: read and compare the tag, walk
// the page table on a miss, write the walk result back, and respond.
// TLB-invalidate commands are queued and executed only between lookups.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_req_*/o_req_ready     lookup request (valid/ready)
//   o_rsp_*/i_rsp_ready     response (hit, fault, payload), held until ready
//   o_walk_*/i_walk_*       page-walk request and its completion pulse
//   i_inv_req/o_inv_ack     invalidate-all request and issue acknowledge
//   o_ram_*/i_ram_*         tag RAM read, write and clear-all ports
//   o_hit_cnt/o_miss_cnt    saturating performance counters
module zap_tlb_lookup_ctrl #(
    parameter  int DEPTH  = 32,
    parameter  int VA_W   = 20,
    parameter  int DATA_W = 24,
    parameter  int CNT_W  = 16,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int TAG_W  = VA_W - IDX_W,
    localparam int ENT_W  = TAG_W + DATA_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    input  logic [VA_W-1:0]   i_req_vpn,
    output logic              o_req_ready,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic              o_rsp_hit,
    output logic              o_rsp_fault,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_walk_req,
    output logic [VA_W-1:0]   o_walk_vpn,
    input  logic              i_walk_done,
    input  logic              i_walk_fault,
    input  logic [DATA_W-1:0] i_walk_data,
    input  logic              i_inv_req,
    output logic              o_inv_ack,
    output logic              o_ram_ren,
    output logic [IDX_W-1:0]  o_ram_raddr,
    output logic              o_ram_wen,
    output logic [IDX_W-1:0]  o_ram_waddr,
    output logic [ENT_W-1:0]  o_ram_wdata,
    output logic              o_ram_inv,
    input  logic [ENT_W-1:0]  i_ram_rdata,
    input  logic              i_ram_rdav,
    output logic [CNT_W-1:0]  o_hit_cnt,
    output logic [CNT_W-1:0]  o_miss_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMP,
        ST_WALK,
        ST_FILL,
        ST_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [VA_W-1:0]     vpn_q, vpn_d;
    logic                inv_pending_q, inv_pending_d;
    logic                discard_q, discard_d;
    logic                rsp_hit_q, rsp_hit_d;
    logic                rsp_fault_q, rsp_fault_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

    logic                tag_match;
    logic                inv_service;

    assign tag_match = i_ram_rdav &&
                       (i_ram_rdata[ENT_W-1:DATA_W] == vpn_q[VA_W-1:IDX_W]);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            vpn_q         <= '0;
            inv_pending_q <= 1'b0;
            discard_q     <= 1'b0;
            rsp_hit_q     <= 1'b0;
            rsp_fault_q   <= 1'b0;
            rsp_data_q    <= '0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            vpn_q         <= vpn_d;
            inv_pending_q <= inv_pending_d;
            discard_q     <= discard_d;
            rsp_hit_q     <= rsp_hit_d;
            rsp_fault_q   <= rsp_fault_d;
            rsp_data_q    <= rsp_data_d;
            hit_cnt_q     <= hit_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        vpn_d         = vpn_q;
        discard_d     = discard_q;
        rsp_hit_d     = rsp_hit_q;
        rsp_fault_d   = rsp_fault_q;
        rsp_data_d    = rsp_data_q;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        inv_service   = 1'b0;

        o_req_ready   = 1'b0;
        o_rsp_valid   = 1'b0;
        o_walk_req    = 1'b0;
        o_walk_vpn    = '0;
        o_inv_ack     = 1'b0;
        o_ram_ren     = 1'b0;
        o_ram_raddr   = '0;
        o_ram_wen     = 1'b0;
        o_ram_inv     = 1'b0;

        // Strobes are held low during the reset cycle so a reset that lands
        // mid-walk or mid-fill never leaks a walk request or a RAM write.
        if (!i_reset) begin
            case (state_q)
                ST_IDLE: begin
                    // A queued invalidate takes the whole IDLE cycle; the
                    // lookup port stays closed until the RAM is cleared.
                    if (inv_pending_q) begin
                        o_ram_inv   = 1'b1;
                        o_inv_ack   = 1'b1;
                        inv_service = 1'b1;
                    end else begin
                        o_req_ready = 1'b1;
                        o_ram_raddr = i_req_vpn[IDX_W-1:0];
                        if (i_req_valid) begin
                            o_ram_ren = 1'b1;
                            vpn_d     = i_req_vpn;
                            state_d   = ST_CMP;
                        end
                    end
                end
                ST_CMP: begin
                    if (tag_match) begin
                        rsp_hit_d   = 1'b1;
                        rsp_fault_d = 1'b0;
                        rsp_data_d  = i_ram_rdata[DATA_W-1:0];
                        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
                        state_d     = ST_WALK;
                    end
                end
                ST_WALK: begin
                    o_walk_req = 1'b1;
                    o_walk_vpn = vpn_q;
                    if (i_walk_done) begin
                        rsp_hit_d = 1'b0;
                        if (i_walk_fault) begin
                            rsp_fault_d = 1'b1;
                            rsp_data_d  = '0;
                            state_d     = ST_RESP;
                        end else begin
                            rsp_fault_d = 1'b0;
                            rsp_data_d  = i_walk_data;
                            state_d     = ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    // An invalidate seen during this lookup makes the walk
                    // result stale, so it is returned but not cached.
                    o_ram_wen = !discard_q;
                    state_d   = ST_RESP;
                end
                ST_RESP: begin
                    o_rsp_valid = 1'b1;
                    if (i_rsp_ready) begin
                        discard_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (i_inv_req && (state_q == ST_CMP || state_q == ST_WALK ||
                              state_q == ST_FILL)) begin
                discard_d = 1'b1;
            end
        end
    end

    // A new invalidate arriving while the previous one is being issued
    // stays queued rather than being absorbed.
    assign inv_pending_d = (inv_pending_q && !inv_service) || i_inv_req;

    assign o_ram_waddr = vpn_q[IDX_W-1:0];
    assign o_ram_wdata = {vpn_q[VA_W-1:IDX_W], rsp_data_q};
    assign o_rsp_hit   = rsp_hit_q;
    assign o_rsp_fault = rsp_fault_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_hit_cnt   = hit_cnt_q;
    assign o_miss_cnt  = miss_cnt_q;

endmodule
